// File: rtl/iter_seq_controller.sv
// rtl/iter_seq_controller.sv - iterative multiply-accumulate sequencing controller
// Optional abort input enabled by ITER_SEQ_CTRL_ABORT_EN.
module iter_seq_controller #(
    parameter int ITER_W   = 8,
    parameter int MULT_LAT = 2,
    parameter int SUM_LAT  = 1
) (
    input  logic              clock,
    input  logic              reset,
    input  logic              start,
    input  logic              conv,
`ifdef ITER_SEQ_CTRL_ABORT_EN
    input  logic              abort,
`endif
    input  logic [ITER_W-1:0] max_iter,
    output logic              read,
    output logic              load_y,
    output logic              select_y,
    output logic              mult,
    output logic              sum,
    output logic              done,
    output logic              busy,
    output logic              timeout,
    output logic [ITER_W-1:0] iter_count
);

    typedef enum logic [2:0] {
        IDLE = 3'd0,
        READ = 3'd1,
        INIT = 3'd2,
        MULT = 3'd3,
        SUM  = 3'd4,
        LOAD = 3'd5,
        DONE = 3'd6
    } state_t;

    localparam logic [3:0] MULT_LAST = 4'(MULT_LAT - 1);
    localparam logic [3:0] SUM_LAST  = 4'(SUM_LAT - 1);

    state_t              state;
    state_t              state_next;
    logic [3:0]          phase;
    logic [ITER_W-1:0]   lim;
    logic [ITER_W-1:0]   iter_next;
    logic                limit_hit;
    logic                abort_hit;

    assign iter_next = iter_count + ITER_W'(1);
    assign limit_hit = (lim != '0) && (iter_next == lim);

`ifdef ITER_SEQ_CTRL_ABORT_EN
    assign abort_hit = abort && busy;
`else
    assign abort_hit = 1'b0;
`endif

    // Moore output decode: strobes depend on the registered state only.
    always_comb begin
        read     = 1'b0;
        load_y   = 1'b0;
        select_y = 1'b0;
        mult     = 1'b0;
        sum      = 1'b0;
        done     = 1'b0;
        busy     = 1'b1;
        case (state)
            IDLE: busy = 1'b0;
            READ: read = 1'b1;
            INIT: load_y = 1'b1;
            MULT: mult = 1'b1;
            SUM:  sum = 1'b1;
            LOAD: begin
                load_y   = 1'b1;
                select_y = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b0;
            end
            default: busy = 1'b0;
        endcase
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE: if (start) state_next = READ;
            READ: state_next = INIT;
            INIT: state_next = MULT;
            MULT: if (phase == MULT_LAST) state_next = SUM;
            SUM:  if (phase == SUM_LAST) state_next = LOAD;
            LOAD: state_next = (conv || limit_hit) ? DONE : MULT;
            DONE: if (!start) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        // Abort wins over convergence and the iteration limit.
        if (abort_hit) state_next = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            phase      <= 4'd0;
            lim        <= '0;
            iter_count <= '0;
            timeout    <= 1'b0;
        end else begin
            state <= state_next;
            if (state_next != state) begin
                phase <= 4'd0;
            end else if (state == MULT || state == SUM) begin
                phase <= phase + 4'd1;
            end
            if (!abort_hit) begin
                if (state == READ) lim <= max_iter;
                if (state == INIT) iter_count <= '0;
                if (state == LOAD) iter_count <= iter_next;
                if (state == IDLE && start) timeout <= 1'b0;
                if (state == LOAD && !conv && limit_hit) timeout <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_iter_seq_controller.sv
// tb/tb_iter_seq_controller.sv - directed self-checking bench for iter_seq_controller
module tb_iter_seq_controller;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       start = 1'b0;
    logic       conv  = 1'b0;
    logic [7:0] max_iter = 8'd0;
    logic       read, load_y, select_y, mult, sum, done, busy, timeout;
    logic [7:0] iter_count;
`ifdef ITER_SEQ_CTRL_ABORT_EN
    logic       abort = 1'b0;
    logic       abort_4 = 1'b0;
`endif

    logic       start_4 = 1'b0;
    logic       conv_4  = 1'b0;
    logic [3:0] max_iter_4 = 4'd0;
    logic       read_4, load_y_4, select_y_4, mult_4, sum_4, done_4, busy_4, timeout_4;
    logic [3:0] iter_count_4;

    int n_compared   = 0;
    int n_mismatched = 0;
    int cycles, mults, sums, loads, inits, reads;
    logic timeout_at_read;
    int seen;

    always #5 clock = ~clock;

    iter_seq_controller #(.ITER_W(8), .MULT_LAT(2), .SUM_LAT(1)) dut (
        .clock(clock), .reset(reset), .start(start), .conv(conv),
`ifdef ITER_SEQ_CTRL_ABORT_EN
        .abort(abort),
`endif
        .max_iter(max_iter), .read(read), .load_y(load_y), .select_y(select_y),
        .mult(mult), .sum(sum), .done(done), .busy(busy), .timeout(timeout),
        .iter_count(iter_count)
    );

    iter_seq_controller #(.ITER_W(4), .MULT_LAT(2), .SUM_LAT(1)) dut_4 (
        .clock(clock), .reset(reset), .start(start_4), .conv(conv_4),
`ifdef ITER_SEQ_CTRL_ABORT_EN
        .abort(abort_4),
`endif
        .max_iter(max_iter_4), .read(read_4), .load_y(load_y_4), .select_y(select_y_4),
        .mult(mult_4), .sum(sum_4), .done(done_4), .busy(busy_4), .timeout(timeout_4),
        .iter_count(iter_count_4)
    );

    task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        n_compared++;
        if (observed !== expected) begin
            n_mismatched++;
            $display("FAIL %s: observed %0d expected %0d", tag, observed, expected);
        end
    endtask

    // Raises start, then counts strobes until done; conv is pulsed in the conv_at-th LOAD (0 = never).
    task automatic run_to_done(input int conv_at, input int budget);
        cycles = 0; mults = 0; sums = 0; loads = 0; inits = 0; reads = 0;
        start = 1'b1;
        @(negedge clock);
        timeout_at_read = timeout;
        while (!done && cycles < budget) begin
            mults += int'(mult);
            sums  += int'(sum);
            reads += int'(read);
            if (load_y && !select_y) inits++;
            if (load_y && select_y) begin
                loads++;
                conv = (loads == conv_at);
            end else begin
                conv = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        conv = 1'b0;
        if (!done) check("done_within_budget", 32'(done), 32'd1);
    endtask

    initial begin
        @(negedge clock);
        check("rst_strobes", {26'd0, read, load_y, select_y, mult, sum, done}, 32'd0);
        check("rst_busy_timeout", {30'd0, busy, timeout}, 32'd0);
        check("rst_iter_count", 32'(iter_count), 32'd0);
        reset = 1'b0;
        @(negedge clock);
        check("idle_after_release", 32'(busy), 32'd0);

        // Convergence in the first LOAD.
        max_iter = 8'd4;
        run_to_done(1, 100);
        check("conv1_cycles", 32'(cycles), 32'd6);
        check("conv1_iter", 32'(iter_count), 32'd1);
        check("conv1_timeout", 32'(timeout), 32'd0);
        check("conv1_mult_cycles", 32'(mults), 32'd2);
        check("conv1_sum_cycles", 32'(sums), 32'd1);
        check("conv1_read_init", 32'(reads * 10 + inits), 32'd11);
        start = 1'b0;
        @(negedge clock);
        check("conv1_idle", {30'd0, done, busy}, 32'd0);

        // Iteration limit with conv never asserted.
        max_iter = 8'd3;
        run_to_done(0, 100);
        check("lim_cycles", 32'(cycles), 32'd14);
        check("lim_iter", 32'(iter_count), 32'd3);
        check("lim_timeout", 32'(timeout), 32'd1);
        check("lim_load_sel_cycles", 32'(loads), 32'd3);
        check("lim_mult_cycles", 32'(mults), 32'd6);

        // Handshake: done holds while start stays high.
        seen = 0;
        repeat (5) begin
            @(negedge clock);
            seen += int'(done);
        end
        check("hs_done_held", 32'(seen), 32'd5);
        start = 1'b0;
        @(negedge clock);
        check("hs_done_fall", {30'd0, done, busy}, 32'd0);
        check("hs_timeout_held", 32'(timeout), 32'd1);
        check("hs_iter_held", 32'(iter_count), 32'd3);
        @(negedge clock);

        // Unlimited run; also confirms timeout cleared on the IDLE->READ edge.
        max_iter = 8'd0;
        run_to_done(10, 200);
        check("unlim_timeout_at_read", 32'(timeout_at_read), 32'd0);
        check("unlim_cycles", 32'(cycles), 32'd42);
        check("unlim_iter", 32'(iter_count), 32'd10);
        check("unlim_timeout", 32'(timeout), 32'd0);
        start = 1'b0;
        @(negedge clock);

        // Reset during MULT of iteration 2.
        start = 1'b1;
        @(negedge clock);
        repeat (6) @(negedge clock);
        check("mid_in_mult2", {31'd0, mult}, 32'd1);
        check("mid_iter_before", 32'(iter_count), 32'd1);
        #2 reset = 1'b1;
        #1;
        check("mid_rst_strobes", {24'd0, read, load_y, select_y, mult, sum, done, busy, timeout}, 32'd0);
        check("mid_rst_iter", 32'(iter_count), 32'd0);
        @(negedge clock);
        start = 1'b0;
        reset = 1'b0;
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            seen += int'(busy) + int'(read) + int'(done);
        end
        check("mid_stays_idle", 32'(seen), 32'd0);

`ifdef ITER_SEQ_CTRL_ABORT_EN
        // Abort in SUM of iteration 2.
        max_iter = 8'd0;
        start = 1'b1;
        @(negedge clock);
        repeat (8) @(negedge clock);
        check("abort_in_sum", {31'd0, sum}, 32'd1);
        abort = 1'b1;
        @(negedge clock);
        abort = 1'b0;
        start = 1'b0;
        check("abort_idle", {25'd0, read, load_y, mult, sum, done, busy, timeout}, 32'd0);
        check("abort_iter", 32'(iter_count), 32'd1);
        seen = 0;
        repeat (3) begin
            @(negedge clock);
            seen += int'(done) + int'(busy);
        end
        check("abort_no_done", 32'(seen), 32'd0);
        check("abort_iter_frozen", 32'(iter_count), 32'd1);
`endif

        // ITER_W=4 unlimited run wraps: conv in the 20th LOAD leaves 20 mod 16.
        max_iter_4 = 4'd0;
        start_4 = 1'b1;
        @(negedge clock);
        loads = 0;
        cycles = 0;
        while (!done_4 && cycles < 300) begin
            if (load_y_4 && select_y_4) begin
                loads++;
                conv_4 = (loads == 20);
            end else begin
                conv_4 = 1'b0;
            end
            @(negedge clock);
            cycles++;
        end
        conv_4 = 1'b0;
        check("wrap_done", 32'(done_4), 32'd1);
        check("wrap_cycles", 32'(cycles), 32'd82);
        check("wrap_iter", 32'(iter_count_4), 32'd4);
        check("wrap_timeout", 32'(timeout_4), 32'd0);
        start_4 = 1'b0;
        @(negedge clock);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
